// File: rtl/sequence_generator_110110.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_generator_110110
//  Description : Serial pattern transmitter. On a start request it sends a
//                programmable number of bursts of PATTERN (MSB first) on a
//                1-bit serial line. Bursts are separated by a programmable
//                idle gap. A per-bit valid qualifier marks pattern bits, and
//                start/busy/done handshake the transfer.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1      rising-edge clock, single clock domain
//    reset_n     in   1      asynchronous active-low reset
//    start       in   1      transfer request, sampled only in IDLE
//    abort       in   1      synchronous cancel, returns to IDLE without done
//    rpt_cnt     in   RPT_W  number of bursts (0 behaves as 1), latched at start
//    gap_len     in   GAP_W  idle cycles between bursts, latched at start
//    dout        out  1      serial data, 0 whenever dout_valid is 0
//    dout_valid  out  1      high on every cycle carrying a pattern bit
//    busy        out  1      high while sending bursts or gaps
//    done        out  1      one-cycle pulse after the last bit of the last burst
// ============================================================================
module sequence_generator_110110 #(
    parameter int                 PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b110110,
    parameter int                 RPT_W   = 4,
    parameter int                 GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RPT_W-1:0] rpt_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    // Bit index width: enough to address PAT_LEN-1 down to 0.
    localparam int                 c_IDX_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [c_IDX_W-1:0] c_MSB_IDX = c_IDX_W'(PAT_LEN - 1);
    localparam logic [RPT_W-1:0]   c_RPT_ONE = RPT_W'(1);
    localparam logic [GAP_W-1:0]   c_GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [c_IDX_W-1:0] r_bit_idx;     // index of the bit currently on the line
    logic [RPT_W-1:0]   r_burst_left;  // bursts remaining, including the current one
    logic [GAP_W-1:0]   r_gap_left;    // gap cycles remaining, including the current one
    logic [GAP_W-1:0]   r_gap_len;     // gap length latched at start

    // Registered outputs
    logic               r_dout;
    logic               r_dout_valid;
    logic               r_busy;
    logic               r_done;

    // Next-state values
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] w_bit_idx_nxt;
    logic [RPT_W-1:0]   w_burst_left_nxt;
    logic [GAP_W-1:0]   w_gap_left_nxt;
    logic [GAP_W-1:0]   w_gap_len_nxt;
    logic               w_dout_nxt;
    logic               w_dout_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Set when the next cycle carries a pattern bit; w_emit_idx selects it.
    logic               w_emit;
    logic [c_IDX_W-1:0] w_emit_idx;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_idx_nxt    = r_bit_idx;
        w_burst_left_nxt = r_burst_left;
        w_gap_left_nxt   = r_gap_left;
        w_gap_len_nxt    = r_gap_len;
        w_emit           = 1'b0;
        w_emit_idx       = c_MSB_IDX;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;

        if (abort) begin
            // Cancel from any state: quiet outputs next cycle, no done pulse.
            w_state_nxt      = ST_IDLE;
            w_bit_idx_nxt    = '0;
            w_burst_left_nxt = '0;
            w_gap_left_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // A zero repeat count still sends one burst.
                        w_burst_left_nxt = (rpt_cnt == '0) ? c_RPT_ONE : rpt_cnt;
                        w_gap_len_nxt    = gap_len;
                        w_state_nxt      = ST_SEND;
                        w_bit_idx_nxt    = c_MSB_IDX;
                        w_emit           = 1'b1;
                        w_emit_idx       = c_MSB_IDX;
                    end
                end

                ST_SEND: begin
                    if (r_bit_idx != '0) begin
                        w_bit_idx_nxt = r_bit_idx - c_IDX_W'(1);
                        w_emit        = 1'b1;
                        w_emit_idx    = r_bit_idx - c_IDX_W'(1);
                    end else if (r_burst_left > c_RPT_ONE) begin
                        w_burst_left_nxt = r_burst_left - c_RPT_ONE;
                        if (r_gap_len != '0) begin
                            w_state_nxt    = ST_GAP;
                            w_gap_left_nxt = r_gap_len;
                            w_busy_nxt     = 1'b1;
                        end else begin
                            // Back-to-back: next burst's MSB follows with no bubble.
                            w_bit_idx_nxt = c_MSB_IDX;
                            w_emit        = 1'b1;
                            w_emit_idx    = c_MSB_IDX;
                        end
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_gap_left <= c_GAP_ONE) begin
                        w_state_nxt   = ST_SEND;
                        w_bit_idx_nxt = c_MSB_IDX;
                        w_emit        = 1'b1;
                        w_emit_idx    = c_MSB_IDX;
                    end else begin
                        w_gap_left_nxt = r_gap_left - c_GAP_ONE;
                        w_busy_nxt     = 1'b1;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not sampled here.
                    w_state_nxt = ST_IDLE;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Data is forced low whenever no pattern bit is being sent.
        w_dout_nxt       = w_emit ? PATTERN[w_emit_idx] : 1'b0;
        w_dout_valid_nxt = w_emit;
        if (w_emit) begin
            w_busy_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_burst_left <= '0;
            r_gap_left   <= '0;
            r_gap_len    <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_burst_left <= w_burst_left_nxt;
            r_gap_left   <= w_gap_left_nxt;
            r_gap_len    <= w_gap_len_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator_110110.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_generator_110110
//  Description : Directed bench for sequence_generator_110110. Each cycle's
//                expected {dout, dout_valid, busy, done} is queued as the
//                stimulus is driven and compared on the following falling
//                edge. A small 110110 detector watches the serial line for
//                the loopback case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_generator_110110;

    localparam int          PAT_LEN = 6;
    localparam logic [5:0]  c_PAT   = 6'b110110;

    logic       clk = 1'b1;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] rpt_cnt;
    logic [3:0] gap_len;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;

    sequence_generator_110110 #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (c_PAT),
        .RPT_W   (4),
        .GAP_W   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .rpt_cnt    (rpt_cnt),
        .gap_len    (gap_len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Loopback 110110 detector (overlapping matches)
    // ------------------------------------------------------------------------
    logic [5:0] det_sh;
    int         det_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_sh  <= '0;
            det_cnt <= 0;
        end else if (dout_valid) begin
            det_sh <= {det_sh[4:0], dout};
            if ({det_sh[4:0], dout} == c_PAT) begin
                det_cnt <= det_cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        bit         is_cnt;
        logic [3:0] exp;
        int         exp_cnt;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] mon_obs;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (!mon_e.is_cnt) begin
                mon_obs = {dout, dout_valid, busy, done};
                assert (mon_obs === mon_e.exp) else begin
                    errors++;
                    $error("FAIL %s: observed {dout,valid,busy,done}=%b expected %b",
                           mon_e.tag, mon_obs, mon_e.exp);
                end
            end else begin
                assert (det_cnt === mon_e.exp_cnt) else begin
                    errors++;
                    $error("FAIL %s: observed detections=%0d expected %0d",
                           mon_e.tag, det_cnt, mon_e.exp_cnt);
                end
            end
        end
    end

    // Queue the outputs expected during the current cycle, then advance.
    task automatic cyc(input string tag, input logic [3:0] exp);
        exp_t e;
        e.is_cnt  = 1'b0;
        e.exp     = exp;
        e.exp_cnt = 0;
        e.tag     = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_det(input string tag, input int n);
        exp_t e;
        e.is_cnt  = 1'b1;
        e.exp     = 4'b0000;
        e.exp_cnt = n;
        e.tag     = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 4'b0000);
    endtask

    task automatic gap_n(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 4'b0010);
    endtask

    task automatic burst(input string tag);
        for (int i = PAT_LEN - 1; i >= 0; i--) cyc(tag, {c_PAT[i], 3'b110});
    endtask

    // Start pulse: the cycle carrying start still shows idle outputs.
    task automatic kick(input string tag, input logic [3:0] r, input logic [3:0] g);
        rpt_cnt = r;
        gap_len = g;
        start   = 1'b1;
        cyc(tag, 4'b0000);
        start   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        rpt_cnt = 4'd0;
        gap_len = 4'd0;
        #1 reset_n = 1'b0;

        // 1: reset, then idle
        idle_n("reset", 2);
        reset_n = 1'b1;
        idle_n("idle_after_reset", 5);

        // 2: single burst, done one cycle after the last bit
        kick("single_start", 4'd1, 4'd0);
        burst("single_bits");
        cyc("single_done", 4'b0001);
        idle_n("single_idle", 2);

        // 3: three bursts back-to-back, then rpt_cnt=0 behaves as 1
        kick("b2b_start", 4'd3, 4'd0);
        burst("b2b_bits1");
        burst("b2b_bits2");
        burst("b2b_bits3");
        cyc("b2b_done", 4'b0001);
        idle_n("b2b_idle", 1);

        kick("rpt0_start", 4'd0, 4'd0);
        burst("rpt0_bits");
        cyc("rpt0_done", 4'b0001);
        idle_n("rpt0_idle", 1);

        // 4: gap of 3; inputs change and start pulses while busy are ignored
        kick("gap_start", 4'd2, 4'd3);
        rpt_cnt = 4'd7;
        gap_len = 4'd1;
        for (int i = PAT_LEN - 1; i >= 0; i--) begin
            start = (i % 2 == 0);
            cyc("gap_bits1", {c_PAT[i], 3'b110});
        end
        start = 1'b1;
        gap_n("gap_idle", 3);
        start = 1'b0;
        burst("gap_bits2");
        // start during DONE is dropped; start in the following IDLE is taken
        rpt_cnt = 4'd1;
        gap_len = 4'd0;
        start   = 1'b1;
        cyc("done_start_ignored", 4'b0001);
        cyc("restart_after_done", 4'b0000);
        start   = 1'b0;
        burst("restart_bits");
        cyc("restart_done", 4'b0001);
        idle_n("restart_idle", 1);

        // maximum gap length and maximum repeat count
        kick("maxgap_start", 4'd2, 4'd15);
        burst("maxgap_bits1");
        gap_n("maxgap_idle", 15);
        burst("maxgap_bits2");
        cyc("maxgap_done", 4'b0001);
        idle_n("maxgap_idle_end", 1);

        kick("maxrpt_start", 4'd15, 4'd0);
        for (int b = 0; b < 15; b++) burst("maxrpt_bits");
        cyc("maxrpt_done", 4'b0001);
        idle_n("maxrpt_idle", 1);

        // 5: abort on the 3rd bit, then immediate restart
        kick("abort_start", 4'd1, 4'd0);
        cyc("abort_bit1", {c_PAT[5], 3'b110});
        cyc("abort_bit2", {c_PAT[4], 3'b110});
        abort = 1'b1;
        cyc("abort_bit3", {c_PAT[3], 3'b110});
        abort = 1'b0;
        start = 1'b1;
        cyc("abort_quiet", 4'b0000);
        start = 1'b0;
        burst("abort_restart_bits");
        cyc("abort_restart_done", 4'b0001);

        // abort together with start in IDLE: no transfer
        abort = 1'b1;
        start = 1'b1;
        cyc("abort_start_same", 4'b0000);
        abort = 1'b0;
        start = 1'b0;
        idle_n("abort_start_none", 3);

        // asynchronous reset while the 4th bit is on the line
        kick("rst_mid_start", 4'd1, 4'd0);
        cyc("rst_mid_bit1", {c_PAT[5], 3'b110});
        cyc("rst_mid_bit2", {c_PAT[4], 3'b110});
        cyc("rst_mid_bit3", {c_PAT[3], 3'b110});
        reset_n = 1'b0;
        idle_n("rst_mid_async", 2);
        reset_n = 1'b1;
        idle_n("rst_mid_idle", 3);

        // 6: loopback into the detector, four bursts back-to-back
        reset_n = 1'b0;
        cyc("loop_reset", 4'b0000);
        reset_n = 1'b1;
        kick("loop_start", 4'd4, 4'd0);
        for (int b = 0; b < 4; b++) burst("loop_bits");
        cyc("loop_done", 4'b0001);
        idle_n("loop_idle", 1);
        // 24 bits of repeated 110 contain 110110 at offsets 0,3,...,18
        chk_det("loop_detections", 7);
        idle_n("final_idle", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
